serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 5 +
 rtl/serial_adder_if.sv | 20 ++
 rtl/serial_adder_full_adder_cell.sv | 11 +
 rtl/serial_adder.sv | 70 +++++++
 tb/tb_serial_adder.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state type and default operand width for the bit-serial adder.
package serial_adder_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake and operand/result bus; sub exists only with SERIAL_ADDER_SUB_EN.
interface serial_adder_if #(parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, sub, input busy, done, sum, carry_out);
  modport slave  (input start, a, b, sub, output busy, done, sum, carry_out);
`else
  modport master (output start, a, b, input busy, done, sum, carry_out);
  modport slave  (input start, a, b, output busy, done, sum, carry_out);
`endif
endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell: combinational 1-bit full adder used for each serial step.
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);
  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial WIDTH-bit adder with start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the sub input (a-b via ~b and carry-in 1).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sb_q, r_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, co_q;
  logic             s, cout, accept, last, sub_w;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = bus.sub;
`else
  assign sub_w = 1'b0;
`endif
  assign accept = bus.start && state_q != RUN;
  assign last   = state_q == RUN && cnt_q == CW'(WIDTH - 1);
  full_adder_cell u_fa (
    .a_i   (sa_q[0]),
    .b_i   (sb_q[0]),
    .cin_i (c_q),
    .s_o   (s),
    .cout_o(cout)
  );
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  always_comb
    state_d = state_q == RUN ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
  always_comb begin
    bus.busy      = state_q == RUN;
    bus.done      = state_q == DONE;
    bus.sum       = sum_q;
    bus.carry_out = co_q;
  end
  // Result bits enter at the MSB so that after WIDTH shifts r_q is aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q  <= '0;
      sb_q  <= '0;
      r_q   <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      c_q   <= 1'b0;
      co_q  <= 1'b0;
    end else if (accept) begin
      sa_q  <= bus.a;
      sb_q  <= sub_w ? ~bus.b : bus.b;
      c_q   <= sub_w;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      sa_q  <= sa_q >> 1;
      sb_q  <= sb_q >> 1;
      c_q   <= cout;
      r_q   <= {s, r_q[WIDTH-1:1]};
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        sum_q <= {s, r_q[WIDTH-1:1]};
        co_q  <= cout;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard-based self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int nchk = 0;
  int nfail = 0;
  logic [8:0] sb_q[$];
  serial_adder_if #(.WIDTH(8)) bus ();
  serial_adder #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic sub);
    logic [8:0] e;
    e = sub ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b});
    sb_q.push_back(e);
  endtask
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic sub);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = sub;
`endif
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic check_result(input string nm);
    logic [8:0] e;
    nchk++;
    if (sb_q.size() == 0) begin
      nfail++;
      $display("FAIL %s: done observed=%0b with empty scoreboard", nm, bus.done);
    end else begin
      e = sb_q.pop_front();
      if ({bus.carry_out, bus.sum} !== e || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
        nfail++;
        $display("FAIL %s: got done=%0b busy=%0b co=%0b sum=%02h, want done=1 busy=0 co=%0b sum=%02h",
                 nm, bus.done, bus.busy, bus.carry_out, bus.sum, e[8], e[7:0]);
      end
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    nchk++;
    if ({bus.busy, bus.done, bus.carry_out, bus.sum} !== 11'd0) begin
      nfail++;
      $display("FAIL reset: busy=%0b done=%0b co=%0b sum=%02h, want all 0", bus.busy, bus.done, bus.carry_out, bus.sum);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_add(input logic [7:0] a, input logic [7:0] b, input string nm);
    int cyc;
    logic [7:0] held;
    drive(a, b, 1'b0);
    push(a, b, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    nchk++;
    if (bus.busy !== 1'b1) begin
      nfail++;
      $display("FAIL %s_busy: busy=%0b want 1", nm, bus.busy);
    end
    wait_done(cyc);
    nchk++;
    if (cyc != 8) begin
      nfail++;
      $display("FAIL %s_latency: %0d cycles, want 8", nm, cyc);
    end
    check_result(nm);
    held = bus.sum;
    repeat (3) begin
      @(negedge clk);
      nchk++;
      if (bus.done !== 1'b0 || bus.sum !== held || held !== 8'(a + b)) begin
        nfail++;
        $display("FAIL %s_hold: done=%0b sum=%02h, want done=0 sum=%02h", nm, bus.done, bus.sum, 8'(a + b));
      end
    end
  endtask
  task automatic test_ignore_mid_run;
    int cyc, ndone;
    drive(8'h5A, 8'h25, 1'b0);
    push(8'h5A, 8'h25, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    drive(8'hFF, 8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    wait_done(cyc);
    check_result("ignore_mid_run");
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    nchk++;
    if (ndone != 0) begin
      nfail++;
      $display("FAIL ignore_extra_done: %0d extra done pulses, want 0", ndone);
    end
  endtask
  task automatic test_reset_mid_run;
    int cyc, ndone;
    drive(8'h33, 8'h44, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nchk++;
    if ({bus.busy, bus.done, bus.carry_out, bus.sum} !== 11'd0) begin
      nfail++;
      $display("FAIL reset_mid_run: busy=%0b done=%0b co=%0b sum=%02h, want all 0", bus.busy, bus.done, bus.carry_out, bus.sum);
    end
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    nchk++;
    if (ndone != 0) begin
      nfail++;
      $display("FAIL reset_no_done: %0d done pulses after reset, want 0", ndone);
    end
    drive(8'h12, 8'h34, 1'b0);
    push(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc);
    check_result("after_reset");
  endtask
  task automatic test_back_to_back;
    int cyc, cyc2;
    drive(8'h5A, 8'h25, 1'b0);
    push(8'h5A, 8'h25, 1'b0);
    @(negedge clk);
    drive(8'h10, 8'h01, 1'b0);
    push(8'h10, 8'h01, 1'b0);
    wait_done(cyc);
    check_result("b2b_first");
    @(negedge clk);
    bus.start = 1'b0;
    cyc2 = 1;
    while (!bus.done && cyc2 < 40) begin
      @(negedge clk);
      cyc2++;
    end
    nchk++;
    if (cyc2 != 9) begin
      nfail++;
      $display("FAIL b2b_spacing: %0d cycles between dones, want 9", cyc2);
    end
    check_result("b2b_second");
    @(negedge clk);
  endtask
`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub(input logic [7:0] a, input logic [7:0] b, input string nm);
    int cyc;
    drive(a, b, 1'b1);
    push(a, b, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.sub = 1'b0;
    wait_done(cyc);
    check_result(nm);
    @(negedge clk);
  endtask
`endif
  initial begin
    test_reset();
    test_add(8'h5A, 8'h25, "add_5a_25");
    test_add(8'hFF, 8'h01, "add_ff_01");
    test_add(8'hC3, 8'hC3, "add_c3_c3");
    test_ignore_mid_run();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub(8'h10, 8'h20, "sub_10_20");
    test_sub(8'h20, 8'h10, "sub_20_10");
`endif
    nchk++;
    if (sb_q.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard_drain: %0d results outstanding, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
